renamer: RTL and testbench

RENAMER -- requirements
Module: renamer

---
 rtl/renamer.sv | 180 ++++++++++++++++++
 tb/tb_renamer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/renamer.sv
// Register renamer: ARN->PRN map table plus circular free list, with one-cycle
// registered output, ROB retire frees, flush restores and squash of the pending output.
module renamer #(
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3,
    parameter int ARN_COUNT    = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [63:0]                            in_pc,
    input  logic [MAX_OPERANDS-1:0]                src_valid,
    input  logic [MAX_OPERANDS-1:0][5:0]           src_arn,
    input  logic [MAX_OPERANDS-1:0]                dst_valid,
    input  logic [MAX_OPERANDS-1:0][5:0]           dst_arn,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [63:0]                            out_pc,
    output logic [MAX_OPERANDS-1:0]                out_src_valid,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  out_src_prn,
    output logic [MAX_OPERANDS-1:0]                out_dst_valid,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  out_dst_prn,
    output logic [MAX_OPERANDS-1:0]                mapping_out_valid,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  mapping_out_prn,
    output logic [MAX_OPERANDS-1:0][5:0]           mapping_out_arn,
    input  logic [MAX_OPERANDS-1:0]                freed_prns_valid,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  freed_prns,
    input  logic [MAX_OPERANDS-1:0]                reset_valid,
    input  logic [MAX_OPERANDS-1:0][5:0]           arn_reset,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  prn_reset,
    input  logic                                   stall_rename
);

    localparam int PRN_COUNT = 1 << PRN_BITS;
    localparam int MAP_IDX   = (ARN_COUNT > 1) ? $clog2(ARN_COUNT) : 1;
    localparam int PUSHES    = 2 * MAX_OPERANDS;

    typedef logic [PRN_BITS-1:0] prn_t;
    typedef logic [PRN_BITS:0]   cnt_t;

    prn_t map_table [ARN_COUNT];
    prn_t free_list [PRN_COUNT];
    prn_t head;
    prn_t tail;
    cnt_t free_count;

    logic accept;
    logic squash;
    prn_t src_prn [MAX_OPERANDS];
    prn_t new_prn [MAX_OPERANDS];
    prn_t old_prn [MAX_OPERANDS];
    cnt_t pop_cnt;
    cnt_t push_cnt;
    logic [PUSHES-1:0] push_en;
    prn_t push_prn [PUSHES];
    prn_t push_off [PUSHES];

    // Handshake: valid/ready both high at a rising edge transfers one item;
    // a squash cycle (stall_rename && out_valid) never counts as a transfer.
    assign in_ready = !stall_rename && (!out_valid || out_ready) &&
                      (free_count >= cnt_t'(MAX_OPERANDS));
    assign accept   = in_valid && in_ready;
    assign squash   = stall_rename && out_valid;

    // Later destination slots see earlier slots of the same instruction as
    // already renamed; sources always see the table before this instruction.
    always_comb begin : rename_c
        pop_cnt = '0;
        for (int i = 0; i < MAX_OPERANDS; i++) begin
            src_prn[i] = map_table[MAP_IDX'(src_arn[i])];
            new_prn[i] = free_list[head + pop_cnt[PRN_BITS-1:0]];
            old_prn[i] = map_table[MAP_IDX'(dst_arn[i])];
            for (int j = 0; j < i; j++) begin
                if (dst_valid[j] && (dst_arn[j] == dst_arn[i])) old_prn[i] = new_prn[j];
            end
            if (dst_valid[i]) pop_cnt = pop_cnt + cnt_t'(1);
        end
    end

    // Retire frees go in first, then squashed PRNs in reverse slot order.
    always_comb begin : push_c
        push_cnt = '0;
        push_en  = '0;
        for (int k = 0; k < PUSHES; k++) begin
            push_prn[k] = '0;
            push_off[k] = '0;
        end
        for (int i = 0; i < MAX_OPERANDS; i++) begin
            push_en[i]  = freed_prns_valid[i];
            push_prn[i] = freed_prns[i];
            push_off[i] = push_cnt[PRN_BITS-1:0];
            if (push_en[i]) push_cnt = push_cnt + cnt_t'(1);
        end
        for (int k = 0; k < MAX_OPERANDS; k++) begin
            push_en[MAX_OPERANDS+k]  = squash && out_dst_valid[MAX_OPERANDS-1-k];
            push_prn[MAX_OPERANDS+k] = out_dst_prn[MAX_OPERANDS-1-k];
            push_off[MAX_OPERANDS+k] = push_cnt[PRN_BITS-1:0];
            if (push_en[MAX_OPERANDS+k]) push_cnt = push_cnt + cnt_t'(1);
        end
    end

    always_ff @(posedge clk) begin : state_q
        if (rst) begin
            for (int i = 0; i < ARN_COUNT; i++) map_table[i] <= prn_t'(i);
            for (int i = 0; i < PRN_COUNT; i++) free_list[i] <= prn_t'(i);
            head       <= prn_t'(ARN_COUNT);
            tail       <= '0;
            free_count <= cnt_t'(PRN_COUNT - ARN_COUNT);
        end else begin
            for (int k = 0; k < PUSHES; k++) begin
                if (push_en[k]) free_list[tail + push_off[k]] <= push_prn[k];
            end
            head       <= accept ? head + pop_cnt[PRN_BITS-1:0] : head;
            tail       <= tail + push_cnt[PRN_BITS-1:0];
            free_count <= free_count + push_cnt - (accept ? pop_cnt : '0);
            if (accept) begin
                for (int i = 0; i < MAX_OPERANDS; i++) begin
                    if (dst_valid[i]) map_table[MAP_IDX'(dst_arn[i])] <= new_prn[i];
                end
            end
            // Descending loop so slot 0's overwritten PRN is the one that sticks.
            if (squash) begin
                for (int i = MAX_OPERANDS - 1; i >= 0; i--) begin
                    if (out_dst_valid[i]) map_table[MAP_IDX'(mapping_out_arn[i])] <= mapping_out_prn[i];
                end
            end
            for (int i = 0; i < MAX_OPERANDS; i++) begin
                if (reset_valid[i]) map_table[MAP_IDX'(arn_reset[i])] <= prn_reset[i];
            end
        end
    end

    always_ff @(posedge clk) begin : out_q
        if (rst) begin
            out_valid         <= 1'b0;
            out_pc            <= '0;
            out_src_valid     <= '0;
            out_src_prn       <= '0;
            out_dst_valid     <= '0;
            out_dst_prn       <= '0;
            mapping_out_valid <= '0;
            mapping_out_prn   <= '0;
            mapping_out_arn   <= '0;
        end else if (accept) begin
            out_valid         <= 1'b1;
            out_pc            <= in_pc;
            out_src_valid     <= src_valid;
            out_dst_valid     <= dst_valid;
            mapping_out_valid <= dst_valid;
            mapping_out_arn   <= dst_arn;
            for (int i = 0; i < MAX_OPERANDS; i++) begin
                out_src_prn[i]     <= src_valid[i] ? src_prn[i] : '0;
                out_dst_prn[i]     <= dst_valid[i] ? new_prn[i] : '0;
                mapping_out_prn[i] <= dst_valid[i] ? old_prn[i] : '0;
            end
        end else if (squash || out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    localparam logic [6:0] ARN_LIMIT = 7'(ARN_COUNT);

    always_ff @(posedge clk) begin : checks_q
        if (!rst) begin
            assert (free_count <= cnt_t'(PRN_COUNT)) else $error("renamer: free list overflow");
            for (int i = 0; i < MAX_OPERANDS; i++) begin
                if (in_valid && src_valid[i])
                    assert ({1'b0, src_arn[i]} < ARN_LIMIT) else $error("renamer: src arn out of range");
                if (in_valid && dst_valid[i])
                    assert ({1'b0, dst_arn[i]} < ARN_LIMIT) else $error("renamer: dst arn out of range");
                if (reset_valid[i])
                    assert ({1'b0, arn_reset[i]} < ARN_LIMIT) else $error("renamer: restore arn out of range");
            end
        end
    end
`endif

endmodule

// File: tb/tb_renamer.sv
// Bench for renamer: directed scenarios plus random traffic, checked by a
// sequential reference model feeding an expected-output queue.
module tb_renamer;

    localparam int PB = 6;
    localparam int MO = 3;
    localparam int AC = 32;
    localparam int NP = 64;
    localparam int EW = 64 + MO * (3 + 3 * PB + 6);

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, out_valid, out_ready, stall_rename;
    logic [63:0] in_pc, out_pc;
    logic [MO-1:0] src_valid, dst_valid, out_src_valid, out_dst_valid, mapping_out_valid;
    logic [MO-1:0] freed_prns_valid, reset_valid;
    logic [MO-1:0][5:0] src_arn, dst_arn, mapping_out_arn, arn_reset;
    logic [MO-1:0][PB-1:0] out_src_prn, out_dst_prn, mapping_out_prn, freed_prns, prn_reset;

    renamer #(.PRN_BITS(PB), .MAX_OPERANDS(MO), .ARN_COUNT(AC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .src_valid(src_valid), .src_arn(src_arn), .dst_valid(dst_valid), .dst_arn(dst_arn),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_src_valid(out_src_valid), .out_src_prn(out_src_prn),
        .out_dst_valid(out_dst_valid), .out_dst_prn(out_dst_prn),
        .mapping_out_valid(mapping_out_valid), .mapping_out_prn(mapping_out_prn),
        .mapping_out_arn(mapping_out_arn), .freed_prns_valid(freed_prns_valid),
        .freed_prns(freed_prns), .reset_valid(reset_valid), .arn_reset(arn_reset),
        .prn_reset(prn_reset), .stall_rename(stall_rename)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model state
    logic [PB-1:0] m_map [64];
    logic [PB-1:0] fl_q[$];
    logic [PB-1:0] retire_q[$];
    logic [EW-1:0] exp_q[$];
    logic m_ov;
    logic [MO-1:0] p_dv;
    logic [MO-1:0][PB-1:0] p_dp, p_mprn;
    logic [MO-1:0][5:0] p_marn;

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [EW-1:0] pack(
        input logic [63:0] pc, input logic [MO-1:0] sv, input logic [MO-1:0][PB-1:0] sp,
        input logic [MO-1:0] dv, input logic [MO-1:0][PB-1:0] dp, input logic [MO-1:0] mv,
        input logic [MO-1:0][PB-1:0] mp, input logic [MO-1:0][5:0] ma);
        for (int i = 0; i < MO; i++) begin
            if (!sv[i]) sp[i] = '0;
            if (!dv[i]) dp[i] = '0;
            if (!mv[i]) begin
                mp[i] = '0;
                ma[i] = '0;
            end
        end
        return {pc, sv, sp, dv, dp, mv, mp, ma};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_map[i] = PB'(i);
        fl_q.delete();
        for (int i = AC; i < NP; i++) fl_q.push_back(PB'(i));
        retire_q.delete();
        exp_q.delete();
        m_ov = 1'b0;
    endtask

    // One cycle of the model, evaluated on the inputs presented this cycle.
    task automatic model_step();
        logic exp_ready, acc, sq, hs;
        logic [PB-1:0] tmp [64];
        logic [MO-1:0][PB-1:0] sp, dp, mp;
        if (rst) begin
            model_reset();
            return;
        end
        exp_ready = !stall_rename && (!m_ov || out_ready) && (fl_q.size() >= MO);
        check("in_ready", EW'(in_ready), EW'(exp_ready));
        check("out_valid", EW'(out_valid), EW'(m_ov));
        acc = in_valid && exp_ready;
        sq  = stall_rename && m_ov;
        hs  = m_ov && out_ready && !stall_rename;
        sp = '0; dp = '0; mp = '0;
        if (acc) begin
            tmp = m_map;
            for (int i = 0; i < MO; i++) if (src_valid[i]) sp[i] = m_map[src_arn[i]];
            for (int i = 0; i < MO; i++) begin
                if (dst_valid[i]) begin
                    dp[i] = fl_q.pop_front();
                    mp[i] = tmp[dst_arn[i]];
                    tmp[dst_arn[i]] = dp[i];
                end
            end
            exp_q.push_back(pack(in_pc, src_valid, sp, dst_valid, dp, dst_valid, mp, dst_arn));
            m_map = tmp;
        end
        for (int i = 0; i < MO; i++) if (freed_prns_valid[i]) fl_q.push_back(freed_prns[i]);
        if (sq) begin
            for (int i = MO - 1; i >= 0; i--) begin
                if (p_dv[i]) begin
                    m_map[p_marn[i]] = p_mprn[i];
                    fl_q.push_back(p_dp[i]);
                end
            end
        end
        for (int i = 0; i < MO; i++) if (reset_valid[i]) m_map[arn_reset[i]] = prn_reset[i];
        if (hs) begin
            for (int i = 0; i < MO; i++) if (p_dv[i]) retire_q.push_back(p_mprn[i]);
        end
        if (acc) begin
            m_ov = 1'b1;
            p_dv = dst_valid; p_dp = dp; p_mprn = mp; p_marn = dst_arn;
        end else if (sq || hs) begin
            m_ov = 1'b0;
        end
    endtask

    // Monitor: pops one expected entry per completed transfer or squash.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!rst && out_valid) begin
                if (stall_rename) begin
                    if (exp_q.size() > 0) exp_q.delete(0);
                end else if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", EW'(1), EW'(0));
                    end else begin
                        check("out_data", pack(out_pc, out_src_valid, out_src_prn, out_dst_valid,
                              out_dst_prn, mapping_out_valid, mapping_out_prn, mapping_out_arn),
                              exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic step();
        #1;
        model_step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        in_valid = 1'b0; src_valid = '0; dst_valid = '0;
        freed_prns_valid = '0; reset_valid = '0; stall_rename = 1'b0;
    endtask

    task automatic set_src(input logic [MO-1:0] sv, input int a0, input int a1, input int a2);
        src_valid = sv;
        src_arn[0] = 6'(a0); src_arn[1] = 6'(a1); src_arn[2] = 6'(a2);
    endtask

    task automatic set_dst(input logic [MO-1:0] dv, input int a0, input int a1, input int a2);
        dst_valid = dv;
        dst_arn[0] = 6'(a0); dst_arn[1] = 6'(a1); dst_arn[2] = 6'(a2);
        in_valid = 1'b1;
        in_pc = {$urandom, $urandom};
    endtask

    task automatic do_reset();
        clear_inputs();
        out_ready = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    int stall_left;

    initial begin
        rst = 1'b1; out_ready = 1'b0; in_pc = '0;
        src_arn = '0; dst_arn = '0; freed_prns = '0; arn_reset = '0; prn_reset = '0;
        clear_inputs();
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        check("reset_out_valid", EW'(out_valid), EW'(0));
        check("reset_free_count", EW'(dut.free_count), EW'(32));
        check("reset_mapping_valid", EW'(mapping_out_valid), EW'(0));
        check("reset_dst_valid", EW'(out_dst_valid), EW'(0));

        // First rename after reset
        out_ready = 1'b1;
        set_src(3'b001, 3, 0, 0); set_dst(3'b001, 3, 0, 0);
        step(); clear_inputs();
        check("first_src_prn", EW'(out_src_prn[0]), EW'(3));
        check("first_dst_prn", EW'(out_dst_prn[0]), EW'(32));
        check("first_map_arn", EW'(mapping_out_arn[0]), EW'(3));
        check("first_map_prn", EW'(mapping_out_prn[0]), EW'(3));
        check("first_map_valid", EW'(mapping_out_valid), EW'(3'b001));
        check("first_free_count", EW'(dut.free_count), EW'(31));
        do_reset();

        // Back-to-back dependent renames
        set_src(3'b000, 0, 0, 0); set_dst(3'b001, 5, 0, 0);
        step();
        check("b2b_dst0", EW'(out_dst_prn[0]), EW'(32));
        check("b2b_old0", EW'(mapping_out_prn[0]), EW'(5));
        set_src(3'b001, 5, 0, 0); set_dst(3'b001, 5, 0, 0);
        step(); clear_inputs();
        check("b2b_src1", EW'(out_src_prn[0]), EW'(32));
        check("b2b_dst1", EW'(out_dst_prn[0]), EW'(33));
        check("b2b_old1", EW'(mapping_out_prn[0]), EW'(32));
        do_reset();

        // Exhaust the free list, then free one PRN
        for (int k = 0; k < 30; k++) begin
            set_src(3'b000, 0, 0, 0); set_dst(3'b001, k, 0, 0);
            step();
        end
        clear_inputs();
        check("drain_free_count", EW'(dut.free_count), EW'(2));
        check("drain_in_ready", EW'(in_ready), EW'(0));
        freed_prns_valid = 3'b001; freed_prns[0] = 6'd40;
        step(); clear_inputs();
        check("refill_in_ready", EW'(in_ready), EW'(1));
        set_src(3'b000, 0, 0, 0); set_dst(3'b011, 0, 1, 0);
        step(); clear_inputs();
        check("refill_pop0", EW'(out_dst_prn[0]), EW'(62));
        check("refill_pop1", EW'(out_dst_prn[1]), EW'(63));
        do_reset();

        // Squash of a stalled pending output
        out_ready = 1'b0;
        set_src(3'b000, 0, 0, 0); set_dst(3'b001, 7, 0, 0);
        step(); clear_inputs();
        check("sq_pending_valid", EW'(out_valid), EW'(1));
        check("sq_pending_dst", EW'(out_dst_prn[0]), EW'(32));
        stall_rename = 1'b1;
        step(); clear_inputs();
        check("sq_out_valid", EW'(out_valid), EW'(0));
        check("sq_map7", EW'(dut.map_table[7]), EW'(7));
        check("sq_free_count", EW'(dut.free_count), EW'(32));
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            set_src(3'b000, 0, 0, 0); set_dst(3'b111, 3 * k, 3 * k + 1, 3 * k + 2);
            step();
        end
        clear_inputs();
        freed_prns_valid = 3'b001; freed_prns[0] = 6'd0;
        step(); clear_inputs();
        set_src(3'b000, 0, 0, 0); set_dst(3'b111, 30, 31, 8);
        step(); clear_inputs();
        check("sq_order0", EW'(out_dst_prn[0]), EW'(63));
        check("sq_order1", EW'(out_dst_prn[1]), EW'(32));
        check("sq_order2", EW'(out_dst_prn[2]), EW'(0));
        do_reset();

        // Flush restores with an ARN collision
        stall_rename = 1'b1;
        set_src(3'b001, 4, 0, 0); set_dst(3'b001, 4, 0, 0);
        reset_valid = 3'b101;
        arn_reset[0] = 6'd4; prn_reset[0] = 6'd4;
        arn_reset[2] = 6'd4; prn_reset[2] = 6'd9;
        step();
        reset_valid = '0;
        step();
        check("flush_in_ready", EW'(in_ready), EW'(0));
        clear_inputs();
        check("flush_map4", EW'(dut.map_table[4]), EW'(9));
        set_src(3'b001, 4, 0, 0); set_dst(3'b000, 0, 0, 0);
        step(); clear_inputs();
        check("flush_src4", EW'(out_src_prn[0]), EW'(9));
        do_reset();

        // Reset overrides a pending output and pending frees
        out_ready = 1'b0;
        set_src(3'b000, 0, 0, 0); set_dst(3'b111, 1, 2, 3);
        step(); clear_inputs();
        check("rst_pending_valid", EW'(out_valid), EW'(1));
        rst = 1'b1;
        freed_prns_valid = 3'b111;
        freed_prns[0] = 6'd1; freed_prns[1] = 6'd2; freed_prns[2] = 6'd3;
        step(); clear_inputs();
        rst = 1'b0;
        check("rst_out_valid", EW'(out_valid), EW'(0));
        check("rst_free_count", EW'(dut.free_count), EW'(32));
        check("rst_dst_valid", EW'(out_dst_valid), EW'(0));
        check("rst_map_valid", EW'(mapping_out_valid), EW'(0));
        out_ready = 1'b1;
        set_src(3'b000, 0, 0, 0); set_dst(3'b111, 1, 2, 3);
        step(); clear_inputs();
        check("rst_pop0", EW'(out_dst_prn[0]), EW'(32));
        check("rst_pop2", EW'(out_dst_prn[2]), EW'(34));

        // Random traffic against the model
        stall_left = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            clear_inputs();
            rst = ($urandom_range(0, 599) == 0);
            if (stall_left > 0) begin
                stall_rename = 1'b1;
                stall_left--;
            end else if ($urandom_range(0, 99) < 5) begin
                stall_left = $urandom_range(1, 3);
            end
            in_valid  = ($urandom_range(0, 99) < 70);
            in_pc     = {$urandom, $urandom};
            src_valid = MO'($urandom);
            dst_valid = MO'($urandom);
            for (int i = 0; i < MO; i++) begin
                src_arn[i] = 6'($urandom_range(0, AC - 1));
                dst_arn[i] = 6'($urandom_range(0, AC - 1));
                if (retire_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                    freed_prns_valid[i] = 1'b1;
                    freed_prns[i] = retire_q.pop_front();
                end
            end
            out_ready = ($urandom_range(0, 99) < 70);
            step();
        end
        clear_inputs();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        check("drained", EW'(exp_q.size()), EW'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
